// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle parametrised ALU with op handshake, iterative multiply and shifts
//
// Purpose: DATA_W-bit ALU for the ucontroller CPU. Single-cycle ops complete on the
// accept edge. op_mul (shift-add, DATA_W cycles) and op_shln/op_shrn (one bit per cycle)
// hold Op_ready low while they run.
//
// Ports:
//   Clk         in   system clock, rising edge
//   Rst_n       in   asynchronous active-low reset
//   Op[4:0]     in   opcode (see OP_* encodings below)
//   Op_valid    in   Op/InData valid, held until accepted
//   Op_ready    out  ALU can accept (transfer = Op_valid & Op_ready)
//   InData      in   load operand
//   OutData     out  ACC while OutData_oe, else 0
//   OutData_oe  out  one-cycle pulse after op_oeacc is accepted
//   Index_reg   out  INDEX register
//   FlagZ/C/E   out  zero / carry-borrow-overflow / compare-or-ascii-error flags
//   Busy        out  multi-cycle op in progress
module alu_mc #(
  parameter int DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [4:0]        Op,
  input  logic              Op_valid,
  output logic              Op_ready,
  input  logic [DATA_W-1:0] InData,
  output logic [DATA_W-1:0] OutData,
  output logic              OutData_oe,
  output logic [DATA_W-1:0] Index_reg,
  output logic              FlagZ,
  output logic              FlagC,
  output logic              FlagE,
  output logic              Busy
);

  localparam int SH_W = $clog2(DATA_W);
  localparam logic [SH_W-1:0] MUL_LAST = SH_W'(DATA_W - 1);

  localparam logic [4:0] OP_NOP       = 5'd0;
  localparam logic [4:0] OP_LDA       = 5'd1;
  localparam logic [4:0] OP_LDB       = 5'd2;
  localparam logic [4:0] OP_LDACC     = 5'd3;
  localparam logic [4:0] OP_LDID      = 5'd4;
  localparam logic [4:0] OP_MVACC2ID  = 5'd5;
  localparam logic [4:0] OP_MVACC2A   = 5'd6;
  localparam logic [4:0] OP_MVACC2B   = 5'd7;
  localparam logic [4:0] OP_ADD       = 5'd8;
  localparam logic [4:0] OP_SUB       = 5'd9;
  localparam logic [4:0] OP_SHIFTL    = 5'd10;
  localparam logic [4:0] OP_SHIFTR    = 5'd11;
  localparam logic [4:0] OP_AND       = 5'd12;
  localparam logic [4:0] OP_OR        = 5'd13;
  localparam logic [4:0] OP_XOR       = 5'd14;
  localparam logic [4:0] OP_CMPE      = 5'd15;
  localparam logic [4:0] OP_CMPL      = 5'd16;
  localparam logic [4:0] OP_CMPG      = 5'd17;
  localparam logic [4:0] OP_ASCII2BIN = 5'd18;
  localparam logic [4:0] OP_BIN2ASCII = 5'd19;
  localparam logic [4:0] OP_OEACC     = 5'd20;
  localparam logic [4:0] OP_MUL       = 5'd21;
  localparam logic [4:0] OP_SHLN      = 5'd22;
  localparam logic [4:0] OP_SHRN      = 5'd23;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_SHIFT} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0]   a_reg, b_reg, acc, index_q;
  logic                flag_z, flag_c, flag_e, oe_q;
  logic [DATA_W-1:0]   mul_a;
  logic [2*DATA_W-1:0] prod;
  logic [SH_W-1:0]     cnt;
  logic                shift_left;

  logic                accept;
  logic [SH_W-1:0]     sh_n;
  logic [DATA_W:0]     add_res, sub_res, mul_sum;
  logic [2*DATA_W-1:0] mul_nxt;
  logic [DATA_W-1:0]   shl1, shr1, sh_step;
  logic                sh_out;
  logic                a2b_ok;
  logic [3:0]          a2b_val;
  logic [7:0]          b2a_char;

  assign Op_ready   = (state == S_IDLE);
  assign Busy       = ~Op_ready;
  assign accept     = Op_valid & Op_ready;
  assign sh_n       = b_reg[SH_W-1:0];
  assign OutData    = oe_q ? acc : '0;
  assign OutData_oe = oe_q;
  assign Index_reg  = index_q;
  assign FlagZ      = flag_z;
  assign FlagC      = flag_c;
  assign FlagE      = flag_e;

  // Unsigned arithmetic in DATA_W+1 bits: the top bit is carry-out for add and borrow for sub.
  assign add_res = {1'b0, a_reg} + {1'b0, b_reg};
  assign sub_res = {1'b0, a_reg} - {1'b0, b_reg};

  // One shift-add step: conditionally add the multiplicand into the high half, then shift
  // the whole product right; the multiplier is consumed from the low half LSB first.
  assign mul_sum = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, mul_a} : '0);
  assign mul_nxt = {mul_sum, prod[DATA_W-1:1]};

  assign shl1    = {acc[DATA_W-2:0], 1'b0};
  assign shr1    = {1'b0, acc[DATA_W-1:1]};
  assign sh_step = shift_left ? shl1 : shr1;
  assign sh_out  = shift_left ? acc[DATA_W-1] : acc[0];

  always_comb begin
    a2b_ok  = 1'b0;
    a2b_val = 4'd0;
    if (acc[7:0] >= 8'h30 && acc[7:0] <= 8'h39) begin
      a2b_ok  = 1'b1;
      a2b_val = acc[3:0];
    end else if (acc[7:0] >= 8'h41 && acc[7:0] <= 8'h46) begin
      a2b_ok  = 1'b1;
      a2b_val = acc[3:0] + 4'd9;   // 'A' = 0x41 -> 1 + 9 = 10
    end
    b2a_char = (acc[3:0] < 4'd10) ? {4'h3, acc[3:0]} : {4'h4, acc[3:0] - 4'd9};
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (Op == OP_MUL)
            state_nxt = S_MUL;
          else if ((Op == OP_SHLN || Op == OP_SHRN) && sh_n != '0)
            state_nxt = S_SHIFT;
        end
      end
      S_MUL:   if (cnt == '0) state_nxt = S_IDLE;
      S_SHIFT: if (cnt == '0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      acc        <= '0;
      index_q    <= '0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      flag_e     <= 1'b0;
      oe_q       <= 1'b0;
      mul_a      <= '0;
      prod       <= '0;
      cnt        <= '0;
      shift_left <= 1'b0;
    end else begin
      oe_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (Op)
              OP_LDA:      a_reg   <= InData;
              OP_LDB:      b_reg   <= InData;
              OP_LDACC:    acc     <= InData;
              OP_LDID:     index_q <= InData;
              OP_MVACC2ID: index_q <= acc;
              OP_MVACC2A:  a_reg   <= acc;
              OP_MVACC2B:  b_reg   <= acc;
              OP_ADD: begin
                acc    <= add_res[DATA_W-1:0];
                flag_c <= add_res[DATA_W];
                flag_z <= (add_res[DATA_W-1:0] == '0);
              end
              OP_SUB: begin
                acc    <= sub_res[DATA_W-1:0];
                flag_c <= sub_res[DATA_W];
                flag_z <= (sub_res[DATA_W-1:0] == '0);
              end
              OP_SHIFTL: begin
                acc    <= shl1;
                flag_c <= acc[DATA_W-1];
                flag_z <= (shl1 == '0);
              end
              OP_SHIFTR: begin
                acc    <= shr1;
                flag_c <= acc[0];
                flag_z <= (shr1 == '0);
              end
              OP_AND: begin
                acc    <= a_reg & b_reg;
                flag_c <= 1'b0;
                flag_z <= ((a_reg & b_reg) == '0);
              end
              OP_OR: begin
                acc    <= a_reg | b_reg;
                flag_c <= 1'b0;
                flag_z <= ((a_reg | b_reg) == '0);
              end
              OP_XOR: begin
                acc    <= a_reg ^ b_reg;
                flag_c <= 1'b0;
                flag_z <= ((a_reg ^ b_reg) == '0);
              end
              OP_CMPE: flag_e <= (a_reg == b_reg);
              OP_CMPL: flag_e <= (a_reg <  b_reg);
              OP_CMPG: flag_e <= (a_reg >  b_reg);
              OP_ASCII2BIN: begin
                if (a2b_ok) begin
                  acc    <= DATA_W'(a2b_val);
                  flag_e <= 1'b0;
                end else begin
                  acc    <= '1;
                  flag_e <= 1'b1;
                end
              end
              OP_BIN2ASCII: acc  <= DATA_W'(b2a_char);
              OP_OEACC:     oe_q <= 1'b1;
              OP_MUL: begin
                mul_a <= a_reg;
                prod  <= {{DATA_W{1'b0}}, b_reg};
                cnt   <= MUL_LAST;
              end
              OP_SHLN, OP_SHRN: begin
                if (sh_n == '0) begin
                  flag_z <= (acc == '0);
                  flag_c <= 1'b0;
                end else begin
                  shift_left <= (Op == OP_SHLN);
                  cnt        <= sh_n - SH_W'(1);
                end
              end
              default: ;   // nop and unused codes are accepted and ignored
            endcase
          end
        end
        S_MUL: begin
          prod <= mul_nxt;
          cnt  <= cnt - SH_W'(1);
          if (cnt == '0) begin
            acc    <= mul_nxt[DATA_W-1:0];
            flag_c <= |mul_nxt[2*DATA_W-1:DATA_W];
            flag_z <= (mul_nxt[DATA_W-1:0] == '0);
          end
        end
        S_SHIFT: begin
          acc    <= sh_step;
          flag_c <= sh_out;
          cnt    <= cnt - SH_W'(1);
          if (cnt == '0) flag_z <= (sh_step == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed self-checking bench for alu_mc at DATA_W=8 and DATA_W=16
module tb_alu_mc;

  localparam logic [4:0] OP_NOP       = 5'd0;
  localparam logic [4:0] OP_LDA       = 5'd1;
  localparam logic [4:0] OP_LDB       = 5'd2;
  localparam logic [4:0] OP_LDACC     = 5'd3;
  localparam logic [4:0] OP_LDID      = 5'd4;
  localparam logic [4:0] OP_MVACC2ID  = 5'd5;
  localparam logic [4:0] OP_ADD       = 5'd8;
  localparam logic [4:0] OP_SUB       = 5'd9;
  localparam logic [4:0] OP_SHIFTL    = 5'd10;
  localparam logic [4:0] OP_SHIFTR    = 5'd11;
  localparam logic [4:0] OP_AND       = 5'd12;
  localparam logic [4:0] OP_OR        = 5'd13;
  localparam logic [4:0] OP_XOR       = 5'd14;
  localparam logic [4:0] OP_CMPE      = 5'd15;
  localparam logic [4:0] OP_CMPL      = 5'd16;
  localparam logic [4:0] OP_CMPG      = 5'd17;
  localparam logic [4:0] OP_ASCII2BIN = 5'd18;
  localparam logic [4:0] OP_BIN2ASCII = 5'd19;
  localparam logic [4:0] OP_OEACC     = 5'd20;
  localparam logic [4:0] OP_MUL       = 5'd21;
  localparam logic [4:0] OP_SHLN      = 5'd22;
  localparam logic [4:0] OP_SHRN      = 5'd23;

  logic        clk, rst_n;
  logic [4:0]  op8, op16;
  logic        vld8, vld16;
  logic [7:0]  din8;
  logic [15:0] din16;
  logic        rdy8, oe8, z8, c8, e8, busy8;
  logic [7:0]  dout8, idx8;
  logic        rdy16, oe16, z16, c16, e16, busy16;
  logic [15:0] dout16, idx16;

  int n_checks = 0;
  int n_errors = 0;

  alu_mc #(.DATA_W(8)) u_dut8 (
    .Clk(clk), .Rst_n(rst_n), .Op(op8), .Op_valid(vld8), .Op_ready(rdy8),
    .InData(din8), .OutData(dout8), .OutData_oe(oe8), .Index_reg(idx8),
    .FlagZ(z8), .FlagC(c8), .FlagE(e8), .Busy(busy8)
  );

  alu_mc #(.DATA_W(16)) u_dut16 (
    .Clk(clk), .Rst_n(rst_n), .Op(op16), .Op_valid(vld16), .Op_ready(rdy16),
    .InData(din16), .OutData(dout16), .OutData_oe(oe16), .Index_reg(idx16),
    .FlagZ(z16), .FlagC(c16), .FlagE(e16), .Busy(busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Tasks start and end on a falling edge; registers written by the op are visible on return.
  task automatic issue8(input logic [4:0] op, input logic [7:0] d);
    int k;
    op8 = op; din8 = d; vld8 = 1'b1; k = 0;
    while (!rdy8 && k < 100) begin @(negedge clk); k++; end
    if (k >= 100) check("issue8_timeout", 32'(k), 32'd0);
    @(negedge clk);
    vld8 = 1'b0; op8 = OP_NOP;
  endtask

  task automatic issue16(input logic [4:0] op, input logic [15:0] d);
    int k;
    op16 = op; din16 = d; vld16 = 1'b1; k = 0;
    while (!rdy16 && k < 100) begin @(negedge clk); k++; end
    if (k >= 100) check("issue16_timeout", 32'(k), 32'd0);
    @(negedge clk);
    vld16 = 1'b0; op16 = OP_NOP;
  endtask

  task automatic count_busy8(output int n);
    n = 0;
    while (!rdy8 && n < 200) begin n++; @(negedge clk); end
  endtask

  task automatic count_busy16(output int n);
    n = 0;
    while (!rdy16 && n < 200) begin n++; @(negedge clk); end
  endtask

  task automatic read_acc8(input string tag, input logic [7:0] exp);
    issue8(OP_OEACC, 8'h00);
    check({tag, "_oe"}, 32'(oe8), 32'd1);
    check(tag, 32'(dout8), 32'(exp));
  endtask

  task automatic read_acc16(input string tag, input logic [15:0] exp);
    issue16(OP_OEACC, 16'h0000);
    check({tag, "_oe"}, 32'(oe16), 32'd1);
    check(tag, 32'(dout16), 32'(exp));
  endtask

  logic [7:0] a2b_in  [7] = '{8'h62, 8'h43, 8'h3A, 8'h39, 8'h47, 8'h30, 8'h46};
  logic [7:0] a2b_exp [7] = '{8'hFF, 8'h0C, 8'hFF, 8'h09, 8'hFF, 8'h00, 8'h0F};
  logic       a2b_err [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [7:0] b2a_in  [5] = '{8'hAB, 8'h09, 8'hF0, 8'h0F, 8'h0A};
  logic [7:0] b2a_exp [5] = '{8'h42, 8'h39, 8'h30, 8'h46, 8'h41};

  initial begin
    int n;
    rst_n = 1'b0;
    op8 = OP_NOP; vld8 = 1'b0; din8 = '0;
    op16 = OP_NOP; vld16 = 1'b0; din16 = '0;
    #1;
    check("rst_ready", 32'(rdy8), 32'd1);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_oe", 32'(oe8), 32'd0);
    check("rst_out", 32'(dout8), 32'd0);
    check("rst_index", 32'(idx8), 32'd0);
    check("rst_flags", 32'({z8, c8, e8}), 32'd0);
    check("rst_ready16", 32'(rdy16), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // add / sub with carry and borrow
    issue8(OP_LDA, 8'hF0); issue8(OP_LDB, 8'h20); issue8(OP_ADD, 8'h00);
    check("add_c", 32'(c8), 32'd1);
    check("add_z", 32'(z8), 32'd0);
    read_acc8("add_acc", 8'h10);
    @(negedge clk);
    check("oe_one_cycle", 32'(oe8), 32'd0);
    check("out_zero_no_oe", 32'(dout8), 32'd0);
    issue8(OP_LDA, 8'h20); issue8(OP_LDB, 8'hF0); issue8(OP_SUB, 8'h00);
    check("sub_borrow", 32'(c8), 32'd1);
    read_acc8("sub_acc", 8'h30);
    issue8(OP_LDA, 8'h80); issue8(OP_LDB, 8'h80); issue8(OP_ADD, 8'h00);
    check("add_wrap_z", 32'(z8), 32'd1);
    check("add_wrap_c", 32'(c8), 32'd1);

    // index register loads
    issue8(OP_LDID, 8'h5A);
    check("ldid", 32'(idx8), 32'h5A);
    issue8(OP_LDACC, 8'h3C); issue8(OP_MVACC2ID, 8'h00);
    check("mvacc2id", 32'(idx8), 32'h3C);

    // logic ops clear carry
    issue8(OP_LDA, 8'hCC); issue8(OP_LDB, 8'hAA); issue8(OP_AND, 8'h00);
    check("and_c", 32'(c8), 32'd0);
    read_acc8("and_acc", 8'h88);
    issue8(OP_OR, 8'h00);  read_acc8("or_acc", 8'hEE);
    issue8(OP_XOR, 8'h00); read_acc8("xor_acc", 8'h66);

    // compares touch only FlagE
    issue8(OP_CMPG, 8'h00); check("cmpg", 32'(e8), 32'd1);
    issue8(OP_CMPL, 8'h00); check("cmpl", 32'(e8), 32'd0);
    issue8(OP_LDB, 8'hCC); issue8(OP_CMPE, 8'h00); check("cmpe", 32'(e8), 32'd1);
    check("cmp_flags_zc", 32'({z8, c8}), 32'd0);
    read_acc8("cmp_acc_kept", 8'h66);

    // ascii conversions
    for (int i = 0; i < 7; i++) begin
      issue8(OP_LDACC, a2b_in[i]); issue8(OP_ASCII2BIN, 8'h00);
      check($sformatf("a2b_e_%0h", a2b_in[i]), 32'(e8), 32'(a2b_err[i]));
      read_acc8($sformatf("a2b_acc_%0h", a2b_in[i]), a2b_exp[i]);
    end
    for (int i = 0; i < 5; i++) begin
      issue8(OP_LDACC, b2a_in[i]); issue8(OP_BIN2ASCII, 8'h00);
      read_acc8($sformatf("b2a_acc_%0h", b2a_in[i]), b2a_exp[i]);
    end

    // single-bit shifts
    issue8(OP_LDACC, 8'h81); issue8(OP_SHIFTL, 8'h00);
    check("shiftl_c", 32'(c8), 32'd1);
    read_acc8("shiftl_acc", 8'h02);
    issue8(OP_SHIFTR, 8'h00);
    check("shiftr_c", 32'(c8), 32'd0);
    read_acc8("shiftr_acc", 8'h01);

    // variable shifts
    issue8(OP_LDACC, 8'h01); issue8(OP_LDB, 8'h05); issue8(OP_SHLN, 8'h00);
    check("shln_busy_out", 32'(busy8), 32'd1);
    count_busy8(n);
    check("shln_busy_cycles", 32'(n), 32'd5);
    check("shln_c", 32'(c8), 32'd0);
    read_acc8("shln_acc", 8'h20);
    issue8(OP_LDACC, 8'h2C); issue8(OP_LDB, 8'h03); issue8(OP_SHRN, 8'h00);
    count_busy8(n);
    check("shrn_busy_cycles", 32'(n), 32'd3);
    check("shrn_c", 32'(c8), 32'd1);
    read_acc8("shrn_acc", 8'h05);
    issue8(OP_LDACC, 8'h00); issue8(OP_LDB, 8'h00); issue8(OP_SHLN, 8'h00);
    check("shln0_ready", 32'(rdy8), 32'd1);
    check("shln0_zc", 32'({z8, c8}), 32'b10);

    // unused opcode is a no-op
    issue8(OP_LDACC, 8'h77); issue8(5'd25, 8'h00);
    read_acc8("op25_acc", 8'h77);

    // 8-bit multiply overflow
    issue8(OP_LDA, 8'h10); issue8(OP_LDB, 8'h10); issue8(OP_MUL, 8'h00);
    count_busy8(n);
    check("mul8_busy_cycles", 32'(n), 32'd8);
    check("mul8_ovf_zc", 32'({z8, c8}), 32'b11);

    // oeacc held during MUL is accepted only after it finishes
    issue8(OP_LDA, 8'h03); issue8(OP_LDB, 8'h05); issue8(OP_MUL, 8'h00);
    op8 = OP_OEACC; vld8 = 1'b1;
    count_busy8(n);
    check("mul_hold_busy_cycles", 32'(n), 32'd8);
    check("mul_hold_oe_early", 32'(oe8), 32'd0);
    @(negedge clk);
    vld8 = 1'b0; op8 = OP_NOP;
    check("mul_hold_oe", 32'(oe8), 32'd1);
    check("mul_hold_acc", 32'(dout8), 32'd15);
    check("mul_hold_zc", 32'({z8, c8}), 32'b00);
    @(negedge clk);
    check("mul_hold_oe_drop", 32'(oe8), 32'd0);

    // 16-bit multiply
    issue16(OP_LDA, 16'h0300); issue16(OP_LDB, 16'h0100); issue16(OP_MUL, 16'h0000);
    count_busy16(n);
    check("mul16_busy_cycles", 32'(n), 32'd16);
    check("mul16_zc", 32'({z16, c16}), 32'b11);
    read_acc16("mul16_acc", 16'h0000);
    issue16(OP_LDA, 16'h00FF); issue16(OP_LDB, 16'h0101); issue16(OP_MUL, 16'h0000);
    count_busy16(n);
    check("mul16b_zc", 32'({z16, c16}), 32'b00);
    read_acc16("mul16b_acc", 16'hFFFF);

    // asynchronous reset in the middle of a multiply
    issue8(OP_LDA, 8'h05); issue8(OP_LDB, 8'h03); issue8(OP_CMPG, 8'h00);
    issue8(OP_LDA, 8'h03); issue8(OP_LDB, 8'h05); issue8(OP_MUL, 8'h00);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 32'(busy8), 32'd1);
    check("pre_rst_e", 32'(e8), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midmul_rst_ready", 32'(rdy8), 32'd1);
    check("midmul_rst_index", 32'(idx8), 32'd0);
    check("midmul_rst_flags", 32'({z8, c8, e8}), 32'd0);
    check("midmul_rst_out", 32'({oe8, dout8}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_acc8("post_rst_acc", 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
